// File: rtl/omp_sparse_readout.sv
// omp_sparse_readout
// Reads the recovered sparse coefficient vector out of RAM_S after the OMP core
// finishes, streams it out on a valid/ready port tagged with index and column,
// then optionally zero-clears RAM_S. busy marks ownership of the RAM_S port.
//
// Ports:
//   clk, rst (async, active-low)
//   start, col_idx         : frame request from the OMP core (IDLE only)
//   RAM_S_A/OE/D/WE, RAM_S_Q : RAM_S port (read data valid one cycle after OE sampled)
//   out_valid/ready/data/index/col/last : coefficient stream
//   busy, done             : port ownership, end-of-frame pulse
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing reads, throttled by FIFO credit
// DRAIN | last read issued, waiting for pipeline and FIFO to empty
// CLEAR | writing zeros to every RAM_S address
// FIN   | pulse done, release the RAM port
module omp_sparse_readout #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int MEM_SIZE    = 256,
  parameter int COL_W       = 10,
  parameter int SKIP_ZERO   = 0,
  parameter int CLEAR_AFTER = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [COL_W-1:0]  col_idx,
  input  logic [DATA_W-1:0] RAM_S_Q,
  output logic [ADDR_W-1:0] RAM_S_A,
  output logic              RAM_S_OE,
  output logic [DATA_W-1:0] RAM_S_D,
  output logic              RAM_S_WE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, CLEAR, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_oe_q, ram_oe_d;
  logic              ram_we_q, ram_we_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_idx_q, pend_idx_d;
  logic [DATA_W-1:0] fifo_data_q [4];
  logic [DATA_W-1:0] fifo_data_d [4];
  logic [ADDR_W-1:0] fifo_idx_q [4];
  logic [ADDR_W-1:0] fifo_idx_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic pop, keep, credit_ok;

  always_comb begin
    pop = (cnt_q != 3'd0) && out_ready;
    // pend_q marks the cycle RAM_S_Q holds the word for pend_idx_q
    keep = pend_q && ((SKIP_ZERO == 0) || (RAM_S_Q != '0) || (pend_idx_q == LAST_ADDR));
    // in-flight reads reserve FIFO space so a capture can never overflow
    credit_ok = (4'(cnt_q) + 4'(ram_oe_q) + 4'(pend_q)) < 4'd4;

    state_d     = state_q;
    col_d       = col_q;
    rd_addr_d   = rd_addr_q;
    ram_a_d     = ram_a_q;
    ram_oe_d    = 1'b0;
    ram_we_d    = 1'b0;
    pend_d      = ram_oe_q;
    pend_idx_d  = ram_a_q;
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + 3'(keep) - 3'(pop);
    done_d      = 1'b0;

    if (keep) begin
      fifo_data_d[wr_ptr_q] = RAM_S_Q;
      fifo_idx_d[wr_ptr_q]  = pend_idx_q;
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          col_d     = col_idx;
          rd_addr_d = '0;
          state_d   = READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          ram_oe_d = 1'b1;
          ram_a_d  = rd_addr_q;
          if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
          else rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!ram_oe_q && !pend_q && (cnt_q == 3'd0)) begin
          if (CLEAR_AFTER != 0) begin
            state_d  = CLEAR;
            ram_we_d = 1'b1;
            ram_a_d  = '0;
          end else begin
            state_d = FIN;
          end
        end
      end
      CLEAR: begin
        if (ram_a_q == LAST_ADDR) begin
          state_d = FIN;
        end else begin
          ram_we_d = 1'b1;
          ram_a_d  = ram_a_q + 1'b1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      rd_addr_q  <= '0;
      ram_a_q    <= '0;
      ram_oe_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      rd_addr_q   <= rd_addr_d;
      ram_a_q     <= ram_a_d;
      ram_oe_q    <= ram_oe_d;
      ram_we_q    <= ram_we_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      fifo_data_q <= fifo_data_d;
      fifo_idx_q  <= fifo_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign RAM_S_A   = ram_a_q;
  assign RAM_S_OE  = ram_oe_q;
  assign RAM_S_WE  = ram_we_q;
  assign RAM_S_D   = '0;
  assign out_valid = (cnt_q != 3'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_index = fifo_idx_q[rd_ptr_q];
  assign out_last  = out_valid && (fifo_idx_q[rd_ptr_q] == LAST_ADDR);
  assign out_col   = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_omp_sparse_readout.sv
// Bench for omp_sparse_readout: instance 0 streams everything and clears RAM,
// instance 1 drops zero coefficients and leaves RAM intact. Expected beats are
// queued when a frame is started; a negedge monitor pops and compares them.
module tb_omp_sparse_readout;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  idx;
    logic [9:0]  col;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  col_idx;
  logic        out_ready;
  logic [15:0] ram_q [2];
  logic [15:0] ram_d [2];
  logic [7:0]  ram_a [2];
  logic        ram_oe [2];
  logic        ram_we [2];
  logic        out_valid [2];
  logic [15:0] out_data [2];
  logic [7:0]  out_index [2];
  logic [9:0]  out_col [2];
  logic        out_last [2];
  logic        busy [2];
  logic        done [2];

  always #5 clk = ~clk;

  omp_sparse_readout #(.DATA_W(16), .ADDR_W(8), .MEM_SIZE(8), .COL_W(10),
                       .SKIP_ZERO(0), .CLEAR_AFTER(1)) dut_full (
    .clk(clk), .rst(rst), .start(start), .col_idx(col_idx),
    .RAM_S_Q(ram_q[0]), .RAM_S_A(ram_a[0]), .RAM_S_OE(ram_oe[0]),
    .RAM_S_D(ram_d[0]), .RAM_S_WE(ram_we[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .out_index(out_index[0]), .out_col(out_col[0]), .out_last(out_last[0]),
    .busy(busy[0]), .done(done[0]));

  omp_sparse_readout #(.DATA_W(16), .ADDR_W(8), .MEM_SIZE(8), .COL_W(10),
                       .SKIP_ZERO(1), .CLEAR_AFTER(0)) dut_skip (
    .clk(clk), .rst(rst), .start(start), .col_idx(col_idx),
    .RAM_S_Q(ram_q[1]), .RAM_S_A(ram_a[1]), .RAM_S_OE(ram_oe[1]),
    .RAM_S_D(ram_d[1]), .RAM_S_WE(ram_we[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .out_index(out_index[1]), .out_col(out_col[1]), .out_last(out_last[1]),
    .busy(busy[1]), .done(done[1]));

  // RAM models; img is copied in when load pulses
  logic [15:0] mem [2][8];
  logic [15:0] img [2][8];
  logic        load;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        for (int i = 0; i < 8; i++) mem[k][i] <= img[k][i];
      end else begin
        if (ram_oe[k]) ram_q[k] <= mem[k][ram_a[k][2:0]];
        if (ram_we[k]) mem[k][ram_a[k][2:0]] <= ram_d[k];
      end
    end
  end

  int    checks = 0;
  int    errors = 0;
  beat_t exp_a[$];
  beat_t exp_b[$];
  int    ready_mode;
  int    done_cnt [2];
  int    we_cnt [2];
  int    dbase [2];
  int    wbase [2];
  logic  stall [2];
  beat_t held [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // monitor: drives ready, compares popped beats, stability under stall, RAM writes
  initial begin
    done_cnt = '{0, 0};
    we_cnt   = '{0, 0};
    stall    = '{1'b0, 1'b0};
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      for (int k = 0; k < 2; k++) begin
        beat_t act, expb;
        act = '{out_data[k], out_index[k], out_col[k], out_last[k]};
        if (!rst) begin
          stall[k] = 1'b0;
        end else begin
          if (stall[k]) chk($sformatf("stall_hold%0d", k), {out_valid[k], act}, {1'b1, held[k]});
          if (out_valid[k] && out_ready) begin
            checks++;
            if ((k == 0 && exp_a.size() == 0) || (k == 1 && exp_b.size() == 0)) begin
              errors++;
              $display("FAIL beat%0d: unexpected beat %0h, none queued", k, act);
            end else begin
              expb = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
              if (act !== expb) begin
                errors++;
                $display("FAIL beat%0d: got data=%0h idx=%0d col=%0d last=%0b expected data=%0h idx=%0d col=%0d last=%0b",
                         k, act.data, act.idx, act.col, act.last, expb.data, expb.idx, expb.col, expb.last);
              end
            end
          end
          stall[k] = out_valid[k] && !out_ready;
          held[k]  = act;
          if (ram_oe[k] && ram_we[k]) begin
            errors++;
            $display("FAIL oe_we%0d: OE and WE both high", k);
          end
          if (ram_we[k]) begin
            chk($sformatf("clear_wr%0d", k), {ram_a[k], ram_d[k], 32'(exp_a.size())},
                {8'(we_cnt[k] - wbase[k]), 16'h0, 32'h0});
            we_cnt[k]++;
          end
          if (done[k]) done_cnt[k]++;
        end
      end
    end
  end

  task automatic load_img();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic push_frame(input logic [9:0] col);
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back('{img[0][i], 8'(i), col, i == 7});
      if (img[1][i] != 16'h0 || i == 7) exp_b.push_back('{img[1][i], 8'(i), col, i == 7});
    end
    dbase = done_cnt;
    wbase = we_cnt;
  endtask

  // start edge is the posedge after the pulse is driven; first valid after 3 edges
  task automatic start_frame(input logic [9:0] col, input bit lat_chk);
    @(negedge clk);
    col_idx = col;
    start   = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (lat_chk) chk("latency_early", 64'(out_valid[0]), 64'h0);
    @(negedge clk);
    if (lat_chk) chk("latency_first", 64'(out_valid[0]), 64'h1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while ((done_cnt[0] == dbase[0] || done_cnt[1] == dbase[1]) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL done_timeout: waited %0d cycles, required done within %0d", n, limit);
    end
  endtask

  task automatic frame_end(input string tag);
    int nz = 0;
    int diff = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (mem[0][i] != 16'h0) nz++;
      if (mem[1][i] != img[1][i]) diff++;
    end
    chk({tag, "_drained"}, 64'(exp_a.size() + exp_b.size()), 64'h0);
    chk({tag, "_done_once"}, {32'(done_cnt[0] - dbase[0]), 32'(done_cnt[1] - dbase[1])}, {32'd1, 32'd1});
    chk({tag, "_we_cycles"}, {32'(we_cnt[0] - wbase[0]), 32'(we_cnt[1] - wbase[1])}, {32'd8, 32'd0});
    chk({tag, "_ram_state"}, {32'(nz), 32'(diff)}, 64'h0);
    chk({tag, "_idle"}, {62'h0, busy[0], busy[1]}, 64'h0);
  endtask

  task automatic chk_quiet(input string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s%0d", tag, k),
          {out_valid[k], ram_oe[k], ram_we[k], busy[k], done[k], ram_a[k], out_data[k],
           out_index[k], out_col[k], out_last[k], ram_d[k]}, 64'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; col_idx = '0; load = 1'b0; ready_mode = 1;
    dbase = '{0, 0}; wbase = '{0, 0};
    repeat (3) @(negedge clk);
    chk_quiet("reset_state");
    rst = 1'b1;

    // frame 1: sparse vector, full stream + clear, skip variant gives 3 beats
    img[0] = '{16'd5, 16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd9};
    img[1] = img[0];
    load_img();
    push_frame(10'd3);
    start_frame(10'd3, 1'b1);
    wait_done(200);
    frame_end("f1");

    // frame 2: all-zero RAM, a second start mid-READ must be ignored
    img[0] = '{default: 16'h0};
    img[1] = '{default: 16'h0};
    load_img();
    push_frame(10'd4);
    start_frame(10'd4, 1'b1);
    col_idx = 10'd6;
    start   = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(200);
    frame_end("f2");

    // frame 3: random backpressure
    img[0] = '{16'h0101, 16'h0, 16'hbeef, 16'h0004, 16'h0, 16'hffff, 16'h0007, 16'h0};
    img[1] = '{16'h0, 16'h0002, 16'h0, 16'h0, 16'h0005, 16'h0, 16'h0006, 16'h0};
    load_img();
    ready_mode = 2;
    push_frame(10'd7);
    start_frame(10'd7, 1'b0);
    wait_done(600);
    ready_mode = 1;
    frame_end("f3");

    // frame 4: async reset mid-READ with beats stalled in the FIFO
    for (int i = 0; i < 8; i++) begin
      img[0][i] = 16'(i + 16);
      img[1][i] = 16'(i + 32);
    end
    load_img();
    ready_mode = 0;
    push_frame(10'd2);
    start_frame(10'd2, 1'b0);
    @(negedge clk);
    chk("pending_before_rst", {62'h0, out_valid[0], busy[0]}, 64'h3);
    #2 rst = 1'b0;
    #1 chk_quiet("async_rst");
    exp_a.delete();
    exp_b.delete();
    repeat (3) @(negedge clk);
    chk("no_done_on_abort", {32'(done_cnt[0] - dbase[0]), 32'(done_cnt[1] - dbase[1])}, 64'h0);
    rst = 1'b1;
    ready_mode = 1;

    // frame 5: clean restart from index 0
    push_frame(10'd5);
    start_frame(10'd5, 1'b1);
    wait_done(200);
    frame_end("f5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
